reorder_buffer: RTL and testbench

- Banked reorder buffer for a 4-wide out-of-order RISC-V core.
- Each row holds 4 micro-op entries (banks/columns 0..3) plus one PC.
- Dispatch allocates a whole row per cycle at the tail and returns its row tag.
- Execution units clear per-entry busy bits; the head row retires in order, releasing its 4 destination physical registers; branch kill invalidates entries by branch mask.

---
 rtl/reorder_buffer_pkg.sv | 49 ++++
 rtl/rob_ptr_ring.sv | 30 +++
 rtl/reorder_buffer.sv | 124 ++++++++++++
 tb/tb_reorder_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types: entry layout, busy-clear command, pointer widths.
// Also provides a helper that tests whether a row lies in the occupied head..tail window.
package reorder_buffer_pkg;
  localparam int WIDTH_BANK = 3;
  localparam int WIDTH_REG  = 7;
  localparam int WIDTH_BRM  = 4;
  localparam int DEPTH      = 2 ** WIDTH_BANK;

  localparam int W_VAL  = 1;
  localparam int W_BUSY = 1;
  localparam int W_UOP  = 7;
  localparam int W_IMM  = 32;

  localparam int OFS_BRM  = 0;
  localparam int OFS_PRD  = OFS_BRM + WIDTH_BRM;
  localparam int OFS_IMM  = OFS_PRD + WIDTH_REG;
  localparam int OFS_UOP  = OFS_IMM + W_IMM;
  localparam int OFS_BUSY = OFS_UOP + W_UOP;
  localparam int OFS_VAL  = OFS_BUSY + W_BUSY;

  localparam int WIDTH      = W_VAL + W_BUSY + W_UOP + W_IMM
                            + WIDTH_REG + WIDTH_BRM;
  localparam int WIDTH_BRST = 1 + WIDTH_BANK + 2;

  typedef logic [WIDTH_BANK-1:0] row_t;
  typedef logic [WIDTH_BANK:0]   cnt_t;

  typedef struct packed {
    logic                 val;
    logic                 busy;
    logic [W_UOP-1:0]     uop;
    logic [W_IMM-1:0]     imm;
    logic [WIDTH_REG-1:0] prd;
    logic [WIDTH_BRM-1:0] brm;
  } entry_t;

  typedef struct packed {
    logic       en;
    row_t       row;
    logic [1:0] col;
  } bclr_t;

  // Row r is occupied when its distance from head is below count.
  function automatic logic row_live(row_t r, row_t head, cnt_t count);
    row_t off;
    off = r - head;
    return {1'b0, off} < count;
  endfunction
endpackage

// File: rtl/rob_ptr_ring.sv
// Head/tail/count bookkeeping for the reorder buffer ring.
// Ports: clk, rst_n, push, pop in; head, tail, count, full, empty out.
module rob_ptr_ring
  import reorder_buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  output row_t head,
  output row_t tail,
  output cnt_t count,
  output logic full,
  output logic empty
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  assign full  = (count == cnt_t'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/reorder_buffer.sv
// Banked 4-wide reorder buffer: row dispatch, busy clear, branch kill, in-order commit.
// Ports: i_clk, i_rst_n, i_dis_*, i_kill, i_rst_busy0..3 in; o_dis_tag, o_com_* out.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_dis_we,
  input  logic [31:0]            i_dis_pc,
  input  logic [4*WIDTH-1:0]     i_dis_data4x,
  input  logic [WIDTH_BRM:0]     i_kill,
  input  logic [WIDTH_BRST-1:0]  i_rst_busy0,
  input  logic [WIDTH_BRST-1:0]  i_rst_busy1,
  input  logic [WIDTH_BRST-1:0]  i_rst_busy2,
  input  logic [WIDTH_BRST-1:0]  i_rst_busy3,
  output logic [WIDTH_BANK-1:0]  o_dis_tag,
  output logic [4*WIDTH_REG-1:0] o_com_prd4x,
  output logic                   o_com_en
);
  row_t   head, tail;
  cnt_t   count;
  logic   full, empty, push, com_en;
  entry_t din [4];
  bclr_t  bc  [4];

  logic [3:0]           val_q  [DEPTH];
  logic [3:0]           busy_q [DEPTH];
  logic [3:0]           val_d  [DEPTH];
  logic [3:0]           busy_d [DEPTH];
  logic [WIDTH_REG-1:0] prd_q  [DEPTH][4];
  logic [WIDTH_BRM-1:0] brm_q  [DEPTH][4];
  logic [W_UOP-1:0]     uop_q  [DEPTH][4];
  logic [W_IMM-1:0]     imm_q  [DEPTH][4];
  logic [31:0]          pc_q   [DEPTH];

  rob_ptr_ring u_ring (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (com_en),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign push      = i_dis_we & ~full;
  assign o_dis_tag = tail;
  assign o_com_en  = com_en;

  always_comb begin
    for (int c = 0; c < 4; c++)
      din[c] = i_dis_data4x[c*WIDTH +: WIDTH];
    bc[0] = i_rst_busy0;
    bc[1] = i_rst_busy1;
    bc[2] = i_rst_busy2;
    bc[3] = i_rst_busy3;
  end

  always_comb begin
    com_en      = ~empty;
    o_com_prd4x = '0;
    for (int c = 0; c < 4; c++)
      if (val_q[head][c] && busy_q[head][c]) com_en = 1'b0;
    for (int c = 0; c < 4; c++)
      if (com_en && val_q[head][c])
        o_com_prd4x[c*WIDTH_REG +: WIDTH_REG] = prd_q[head][c];
  end

  always_comb begin
    logic live;
    live = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      val_d[r]  = val_q[r];
      busy_d[r] = busy_q[r];
      live      = row_live(row_t'(r), head, count);
      for (int c = 0; c < 4; c++) begin
        if (live) begin
          if (i_kill[WIDTH_BRM] &&
              |(brm_q[r][c] & i_kill[WIDTH_BRM-1:0]))
            val_d[r][c] = 1'b0;
          for (int k = 0; k < 4; k++)
            if (bc[k].en && bc[k].row == row_t'(r) &&
                bc[k].col == 2'(c))
              busy_d[r][c] = 1'b0;
        end
      end
      if (com_en && row_t'(r) == head) val_d[r] = '0;
      // Tail row is unoccupied, so this overrides nothing live.
      if (push && row_t'(r) == tail)
        for (int c = 0; c < 4; c++) begin
          val_d[r][c]  = din[c].val;
          busy_d[r][c] = din[c].busy;
        end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        val_q[r]  <= '0;
        busy_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        val_q[r]  <= val_d[r];
        busy_q[r] <= busy_d[r];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_q[tail] <= i_dis_pc;
      for (int c = 0; c < 4; c++) begin
        prd_q[tail][c] <= din[c].prd;
        brm_q[tail][c] <= din[c].brm;
        uop_q[tail][c] <= din[c].uop;
        imm_q[tail][c] <= din[c].imm;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed dispatch/clear/kill vectors.
// Expected commit prd rows are queued at issue and popped by a commit monitor.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dis_we;
  logic [31:0]            dis_pc;
  logic [4*WIDTH-1:0]     dis_data;
  logic [WIDTH_BRM:0]     kill;
  logic [WIDTH_BRST-1:0]  rb [4];
  logic [WIDTH_BANK-1:0]  dis_tag;
  logic [4*WIDTH_REG-1:0] com_prd;
  logic                   com_en;

  int vectors     = 0;
  int miscompares = 0;
  logic [4*WIDTH_REG-1:0] exp_q [$];

  reorder_buffer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dis_we     (dis_we),
    .i_dis_pc     (dis_pc),
    .i_dis_data4x (dis_data),
    .i_kill       (kill),
    .i_rst_busy0  (rb[0]),
    .i_rst_busy1  (rb[1]),
    .i_rst_busy2  (rb[2]),
    .i_rst_busy3  (rb[3]),
    .o_dis_tag    (dis_tag),
    .o_com_prd4x  (com_prd),
    .o_com_en     (com_en)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] p4(int a, int b, int c, int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic logic [4*WIDTH-1:0] mk_row(logic v, logic b,
                                                 int base,
                                                 logic [3:0] brm);
    logic [4*WIDTH-1:0] r;
    entry_t e;
    for (int c = 0; c < 4; c++) begin
      e.val  = v;
      e.busy = b;
      e.uop  = 7'h11;
      e.imm  = 32'(base * 3);
      e.prd  = 7'(base + c);
      e.brm  = brm;
      r[c*WIDTH +: WIDTH] = e;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_clr(int row, logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      rb[k] = {mask[k], 3'(row), 2'(k)};
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (com_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL commit_unexpected: got %0h expected none",
                   com_prd);
        end else begin
          check("commit_prd", 32'(com_prd), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_prd", 32'(com_prd), 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; dis_we = 1'b0; dis_pc = '0;
    dis_data = '0; kill = '0;
    set_clr(0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_tag", 32'(dis_tag), 0);
    check("rst_com_en", 32'(com_en), 0);
    check("rst_prd", 32'(com_prd), 0);
    rst_n = 1'b1;
    step();
    check("idle_tag", 32'(dis_tag), 0);
    check("idle_com_en", 32'(com_en), 0);

    for (int r = 0; r < 3; r++) begin
      check("dis_tag_a", 32'(dis_tag), 32'(r));
      dis_we = 1'b1; dis_pc = 32'(r * 16);
      dis_data = mk_row(1, 1, 4 * r, 4'b0000);
      step();
    end
    dis_we = 1'b0;
    check("busy_no_commit", 32'(com_en), 0);

    set_clr(0, 4'hF);
    exp_q.push_back(p4(0, 1, 2, 3));
    step();
    set_clr(0, 4'h0);
    check("row0_com_en", 32'(com_en), 1);
    step();
    check("row1_busy", 32'(com_en), 0);
    check("tag_after3", 32'(dis_tag), 3);

    set_clr(1, 4'b0111);
    step();
    set_clr(0, 4'h0);
    check("row1_partial", 32'(com_en), 0);
    set_clr(1, 4'b1000);
    exp_q.push_back(p4(4, 5, 6, 7));
    step();
    set_clr(0, 4'h0);
    check("row1_com_en", 32'(com_en), 1);
    step();

    set_clr(2, 4'hF);
    exp_q.push_back(p4(8, 9, 10, 11));
    step();
    set_clr(0, 4'h0);
    step();

    for (int i = 0; i < 5; i++) begin
      check("dis_tag_empty", 32'(dis_tag), 32'(3 + i));
      dis_we = 1'b1;
      dis_data = mk_row(0, 0, 0, 4'b0000);
      exp_q.push_back('0);
      step();
    end
    dis_we = 1'b0;
    step();
    check("wrap_tag", 32'(dis_tag), 0);
    check("wrap_com_en", 32'(com_en), 0);

    for (int r = 0; r < 8; r++) begin
      check("dis_tag_fill", 32'(dis_tag), 32'(r));
      dis_we = 1'b1;
      dis_data = mk_row(1, 1, 16 + 4 * r,
                        (r < 4) ? 4'b0001 : 4'b0010);
      step();
    end
    check("full_tag", 32'(dis_tag), 0);
    dis_data = mk_row(1, 1, 100, 4'b0010);
    step();
    dis_we = 1'b0;
    check("full_ignored_tag", 32'(dis_tag), 0);
    check("full_com_en", 32'(com_en), 0);

    kill = {1'b1, 4'b0001};
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    step();
    kill = '0;
    check("kill_com_en", 32'(com_en), 1);
    repeat (4) step();
    check("unkilled_busy", 32'(com_en), 0);

    for (int r = 4; r < 8; r++) begin
      set_clr(r, 4'hF);
      exp_q.push_back(p4(16 + 4 * r, 17 + 4 * r,
                         18 + 4 * r, 19 + 4 * r));
      step();
      set_clr(0, 4'h0);
      check("tail_rows_com_en", 32'(com_en), 1);
      step();
    end
    check("end_com_en", 32'(com_en), 0);
    check("end_tag", 32'(dis_tag), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
